// File: rtl/ser_pkg.sv
// Shared constants and FSM encoding for the wide word serializer.
// Upstream C-bus words are split into LSB-first beats.
package ser_pkg;

    localparam int WORD_W = 121;
    localparam int BEAT_W = 32;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

    localparam int NBEATS = ceil_div(WORD_W, BEAT_W);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

endpackage

// File: rtl/wide_word_serializer.sv
// Captures one wide word and replays it as NBEATS narrow beats, LSB first.
// A new word may load on the last-beat handshake so words stream without bubbles.
module wide_word_serializer
    import ser_pkg::*;
#(
    parameter int WORD_W = ser_pkg::WORD_W,
    parameter int BEAT_W = ser_pkg::BEAT_W,
    localparam int NBEATS = ser_pkg::ceil_div(WORD_W, BEAT_W),
    localparam int BIDX_W = (NBEATS > 1) ? $clog2(NBEATS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [WORD_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [BEAT_W-1:0] out_data,
    output logic [BIDX_W-1:0] out_beat,
    output logic              out_last,
    input  logic              out_ready,
    output logic [15:0]       word_cnt
);

    localparam int PAD_W = NBEATS * BEAT_W;

    state_t              state_q;
    logic [BIDX_W-1:0]   beat_q;
    logic [WORD_W-1:0]   hold_q;
    logic [15:0]         word_cnt_q;
    logic [PAD_W-1:0]    padded;
    logic                accept;
    logic                fire;
    logic                last_fire;

    assign out_valid = (state_q == SEND);
    assign out_beat  = beat_q;
    assign out_last  = out_valid && (beat_q == BIDX_W'(NBEATS - 1));
    assign in_ready  = (state_q == IDLE) || (out_last && out_ready);
    assign word_cnt  = word_cnt_q;

    assign accept    = in_valid && in_ready;
    assign fire      = out_valid && out_ready;
    assign last_fire = fire && out_last;

    // Bits above the word are zero so the top beat is zero-extended.
    always_comb begin
        padded = '0;
        padded[WORD_W-1:0] = hold_q;
    end

    always_comb begin
        out_data = '0;
        if (out_valid) begin
            out_data = padded[beat_q*BEAT_W +: BEAT_W];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            beat_q  <= '0;
            hold_q  <= '0;
        end else if (accept) begin
            state_q <= SEND;
            beat_q  <= '0;
            hold_q  <= in_data;
        end else if (fire) begin
            if (out_last) begin
                state_q <= IDLE;
                beat_q  <= '0;
            end else begin
                beat_q  <= beat_q + BIDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            word_cnt_q <= '0;
        end else if (last_fire && (word_cnt_q != 16'hFFFF)) begin
            word_cnt_q <= word_cnt_q + 16'd1;
        end
    end

endmodule

// File: tb/tb_wide_word_serializer.sv
// Directed bench for wide_word_serializer: beat order, streaming, stalls,
// reset abort, X/Z passthrough and count saturation.
module tb_wide_word_serializer;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic [120:0] in_data;
    logic         in_ready;
    logic         out_valid;
    logic [31:0]  out_data;
    logic [1:0]   out_beat;
    logic         out_last;
    logic         out_ready;
    logic [15:0]  word_cnt;

    int errors;
    int checks;
    logic [15:0] exp_cnt;

    wide_word_serializer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_beat  (out_beat),
        .out_last  (out_last),
        .out_ready (out_ready),
        .word_cnt  (word_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_beat(input string tag, input logic [31:0] d,
                            input int k, input logic rdy);
        chk({tag, " valid"}, 128'(out_valid), 128'(1'b1));
        chk({tag, " data"}, 128'(out_data), 128'(d));
        chk({tag, " beat"}, 128'(out_beat), 128'(k));
        chk({tag, " last"}, 128'(out_last), 128'(k == 3));
        chk({tag, " in_ready"}, 128'(in_ready), 128'(rdy));
    endtask

    task automatic bump();
        if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
    endtask

    // One isolated word with out_ready held high; checks all four beats.
    task automatic run_word(input string tag, input logic [120:0] w,
                            input logic [31:0] b0, input logic [31:0] b1,
                            input logic [31:0] b2, input logic [31:0] b3);
        logic [31:0] exp_b [4];
        exp_b[0] = b0;
        exp_b[1] = b1;
        exp_b[2] = b2;
        exp_b[3] = b3;
        in_valid  = 1'b1;
        in_data   = w;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk_beat($sformatf("%s b%0d", tag, k), exp_b[k], k, k == 3);
            @(negedge clk);
        end
        bump();
        chk({tag, " idle valid"}, 128'(out_valid), 128'(1'b0));
        chk({tag, " cnt"}, 128'(word_cnt), 128'(exp_cnt));
    endtask

    logic [120:0] w1, w2, w3, wx;
    logic [31:0]  bx1;
    logic [15:0]  xz;
    logic [31:0]  seq_d [8];

    initial begin
        errors    = 0;
        checks    = 0;
        exp_cnt   = 16'd0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        w1 = {25'h0000001, 32'hABCDEF01, 32'h13579BDF, 32'h2468ACE0};
        w2 = {25'h1234567, 32'hDEADBEEF, 32'hCAFEBABE, 32'h0BADF00D};
        w3 = {25'h1FFFFFF, 32'h00000000, 32'hFFFFFFFF, 32'hA5A5A5A5};

        @(negedge clk);
        @(negedge clk);
        chk("rst valid", 128'(out_valid), 128'(1'b0));
        chk("rst data", 128'(out_data), 128'(32'h0));
        chk("rst beat", 128'(out_beat), 128'(2'd0));
        chk("rst last", 128'(out_last), 128'(1'b0));
        chk("rst in_ready", 128'(in_ready), 128'(1'b1));
        chk("rst cnt", 128'(word_cnt), 128'(16'h0));
        rst_n = 1'b1;

        // Reset during beat 2 discards the word.
        in_valid  = 1'b1;
        in_data   = w1;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk_beat("abort b0", 32'h2468ACE0, 0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk_beat("abort b2", 32'hABCDEF01, 2, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort valid", 128'(out_valid), 128'(1'b0));
        chk("abort in_ready", 128'(in_ready), 128'(1'b1));
        chk("abort cnt", 128'(word_cnt), 128'(exp_cnt));
        @(negedge clk);
        chk("abort no beat", 128'(out_valid), 128'(1'b0));
        chk("abort data", 128'(out_data), 128'(32'h0));

        run_word("w1", w1, 32'h2468ACE0, 32'h13579BDF,
                 32'hABCDEF01, 32'h00000001);

        // Back-to-back words, in_valid held high.
        seq_d[0] = 32'h0BADF00D; seq_d[1] = 32'hCAFEBABE;
        seq_d[2] = 32'hDEADBEEF; seq_d[3] = 32'h01234567;
        seq_d[4] = 32'hA5A5A5A5; seq_d[5] = 32'hFFFFFFFF;
        seq_d[6] = 32'h00000000; seq_d[7] = 32'h01FFFFFF;
        in_valid  = 1'b1;
        in_data   = w2;
        out_ready = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            chk_beat($sformatf("b2b %0d", i), seq_d[i], i % 4, (i % 4) == 3);
            if (i == 3) in_data = w3;
            if (i == 7) in_valid = 1'b0;
            @(negedge clk);
        end
        bump();
        bump();
        chk("b2b idle", 128'(out_valid), 128'(1'b0));
        chk("b2b cnt", 128'(word_cnt), 128'(exp_cnt));

        // Stall on beat 1; an offered word during the stall is ignored.
        in_valid  = 1'b1;
        in_data   = w2;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk_beat("stall b0", 32'h0BADF00D, 0, 1'b0);
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = w3;
        chk("stall rdy0", 128'(in_ready), 128'(1'b0));
        for (int i = 0; i < 3; i++) begin
            chk_beat($sformatf("stall hold %0d", i), 32'hCAFEBABE, 1, 1'b0);
            if (i == 2) begin
                out_ready = 1'b1;
                in_valid  = 1'b0;
            end
            @(negedge clk);
        end
        chk_beat("stall b2", 32'hDEADBEEF, 2, 1'b0);
        @(negedge clk);
        chk_beat("stall b3", 32'h01234567, 3, 1'b1);
        @(negedge clk);
        bump();
        chk("stall idle", 128'(out_valid), 128'(1'b0));
        chk("stall cnt", 128'(word_cnt), 128'(exp_cnt));

        // X/Z in bits [51:36] appear in beat 1 bits [19:4].
        xz = 16'bxxxx_zzzz_x0z1_01xz;
        wx = w1;
        wx[51:36] = xz;
        bx1 = 32'h13579BDF;
        bx1[19:4] = xz;
        run_word("xz", wx, 32'h2468ACE0, bx1, 32'hABCDEF01, 32'h00000001);

        // Saturation.
        force dut.word_cnt_q = 16'hFFFE;
        #1;
        release dut.word_cnt_q;
        exp_cnt = 16'hFFFE;
        chk("sat preload", 128'(word_cnt), 128'(16'hFFFE));
        run_word("sat1", w3, 32'hA5A5A5A5, 32'hFFFFFFFF,
                 32'h00000000, 32'h01FFFFFF);
        run_word("sat2", w2, 32'h0BADF00D, 32'hCAFEBABE,
                 32'hDEADBEEF, 32'h01234567);
        run_word("sat3", w1, 32'h2468ACE0, 32'h13579BDF,
                 32'hABCDEF01, 32'h00000001);
        chk("sat final", 128'(word_cnt), 128'(16'hFFFF));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
